// File: rtl/score_digits.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Result is committed to the renderer only on frame_sync so digits never tear.
module score_digits #(
  parameter int W = 14,
  parameter int L = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       value,
  input  logic               load,
  input  logic               frame_sync,
  output logic [L-1:0][3:0]  digits,
  output logic               busy,
  output logic               overflow
);

  function automatic int dec_digits(input int w, input int l);
    longint m;
    int     n;
    m = (longint'(1) << w) - 1;
    n = 1;
    while (m >= 10) begin
      m = m / 10;
      n = n + 1;
    end
    return (n > l) ? n : l;
  endfunction

  localparam int          ND  = dec_digits(W, L);
  localparam int          CW  = $clog2(W + 1);
  localparam logic [63:0] LIM = 64'(10 ** L);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        bin_q, bin_d;
  logic [ND*4-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_cap_q, ovf_cap_d;
  logic                pend_q, pend_d;
  logic [W-1:0]        pval_q, pval_d;
  logic [L-1:0][3:0]   sh_dig_q, sh_dig_d;
  logic                sh_ovf_q, sh_ovf_d;
  logic [L-1:0][3:0]   dig_q, dig_d;
  logic                ovf_q, ovf_d;

  logic [ND*4-1:0]     adj;
  logic [ND*4+W-1:0]   shifted;
  logic                start;
  logic [W-1:0]        start_val;

  // Add-3 correction applied before each shift
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < ND; k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    pend_d    = pend_q;
    pval_d    = pval_q;
    sh_dig_d  = sh_dig_q;
    sh_ovf_d  = sh_ovf_q;
    dig_d     = dig_q;
    ovf_d     = ovf_q;
    start     = 1'b0;
    start_val = value;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          start  = 1'b1;
          pend_d = 1'b0;
        end else if (pend_q) begin
          start     = 1'b1;
          start_val = pval_q;
          pend_d    = 1'b0;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < L; i++) begin
          sh_dig_d[i] = ovf_cap_q ? 4'd9 : bcd_q[(L-1-i)*4 +: 4];
        end
        sh_ovf_d = ovf_cap_q;
        if (pend_q) begin
          start     = 1'b1;
          start_val = pval_q;
          pend_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      bin_d     = start_val;
      bcd_d     = '0;
      cnt_d     = CW'(W);
      ovf_cap_d = ({{(64-W){1'b0}}, start_val} >= LIM);
      state_d   = SHIFT;
    end

    // A load arriving outside IDLE (COMMIT included) waits; newest wins
    if (load && state_q != IDLE) begin
      pend_d = 1'b1;
      pval_d = value;
    end

    if (frame_sync) begin
      dig_d = sh_dig_q;
      ovf_d = sh_ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      pend_q    <= 1'b0;
      pval_q    <= '0;
      sh_dig_q  <= '0;
      sh_ovf_q  <= 1'b0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      pend_q    <= pend_d;
      pval_q    <= pval_d;
      sh_dig_q  <= sh_dig_d;
      sh_ovf_q  <= sh_ovf_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
    end
  end

  assign digits   = dig_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_score_digits.sv
// Bench for score_digits: timeline model of conversions plus
// directed vectors with hand-computed display values.
module tb_score_digits;
  localparam int W   = 14;
  localparam int L   = 4;
  localparam int LIM = 10 ** L;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic              frame_sync = 1'b0;
  logic [W-1:0]      value = '0;
  logic [L-1:0][3:0] digits;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_digits #(.W(W), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .frame_sync(frame_sync),
    .digits    (digits),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Model: a job started at edge c lands in the shadow at edge c+W+1
  int cyc = 0;
  bit running = 0;
  bit pend = 0;
  bit was_running = 0;
  bit start = 0;
  int commit_at = 0;
  int run_val = 0;
  int pend_val = 0;
  int sv = 0;
  int sh_val = 0;
  bit sh_ovf = 0;
  int disp_val = 0;
  bit disp_ovf = 0;
  bit exp_busy = 0;

  function automatic int sat(input int v);
    return (v >= LIM) ? LIM - 1 : v;
  endfunction

  function automatic logic [4*L-1:0] to_digits(input int v);
    logic [4*L-1:0] d;
    d = '0;
    for (int i = 0; i < L; i++) d[i*4 +: 4] = 4'((v / (10 ** (L-1-i))) % 10);
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; running = 0; pend = 0; sh_val = 0; sh_ovf = 0;
      disp_val = 0; disp_ovf = 0; exp_busy = 0;
    end else begin
      was_running = running;
      start = 0;
      if (frame_sync) begin
        disp_val = sh_val;
        disp_ovf = sh_ovf;
      end
      if (running && cyc == commit_at) begin
        sh_val  = sat(run_val);
        sh_ovf  = (run_val >= LIM);
        running = 0;
        if (pend) begin
          start = 1; sv = pend_val; pend = 0;
        end
      end
      if (load) begin
        if (!was_running) begin
          start = 1; sv = int'(value); pend = 0;
        end else begin
          pend = 1; pend_val = int'(value);
        end
      end else if (!was_running && pend) begin
        start = 1; sv = pend_val; pend = 0;
      end
      if (start) begin
        running = 1; run_val = sv; commit_at = cyc + W + 1;
      end
      cyc = cyc + 1;
      exp_busy = running || pend;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (digits !== to_digits(disp_val) || overflow !== disp_ovf ||
        busy !== exp_busy) begin
      errors++;
      $display("FAIL cycle_model t=%0t: digits=%h ovf=%b busy=%b expected digits=%h ovf=%b busy=%b",
               $time, digits, overflow, busy, to_digits(disp_val), disp_ovf, exp_busy);
    end
    for (int i = 0; i < L; i++) begin
      if (digits[i] > 4'd9) begin
        errors++;
        $display("FAIL digit_range t=%0t: digit %0d = %0d, expected 0..9", $time, i, digits[i]);
      end
    end
  end

  task automatic check_lit(input string name, input int d0, input int d1,
                           input int d2, input int d3, input bit eovf, input bit ebusy);
    logic [15:0] e;
    e = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    checks++;
    if (digits !== e || overflow !== eovf || busy !== ebusy) begin
      errors++;
      $display("FAIL %s: digits=%h ovf=%b busy=%b, expected digits=%h ovf=%b busy=%b",
               name, digits, overflow, busy, e, eovf, ebusy);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input int v);
    value = W'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, k);
    end
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_lit("reset", 0, 0, 0, 0, 0, 0);

    do_load(1234);
    n = 0;
    repeat (20) begin
      if (busy) n++;
      @(negedge clk);
    end
    check_int("busy_len_1234", n, 15);
    check_lit("hold_without_fs", 0, 0, 0, 0, 0, 0);
    pulse_fs();
    check_lit("show_1234", 1, 2, 3, 4, 0, 0);

    do_load(10000);
    wait_idle();
    pulse_fs();
    check_lit("saturate_10000", 9, 9, 9, 9, 1, 0);
    do_load(7);
    wait_idle();
    pulse_fs();
    check_lit("show_7", 0, 0, 0, 7, 0, 0);

    do_load(0);
    repeat (2) @(negedge clk);
    do_load(9999);
    repeat (14) @(negedge clk);
    pulse_fs();
    check_lit("b2b_first_0", 0, 0, 0, 0, 0, 1);
    wait_idle();
    pulse_fs();
    check_lit("b2b_second_9999", 9, 9, 9, 9, 0, 0);

    do_load(5000);
    repeat (3) @(negedge clk);
    do_load(111);
    repeat (2) @(negedge clk);
    do_load(222);
    wait_idle();
    pulse_fs();
    check_lit("newest_pending_222", 0, 2, 2, 2, 0, 0);

    do_load(42);
    repeat (14) @(negedge clk);
    pulse_fs();
    check_lit("fs_on_commit_old", 0, 2, 2, 2, 0, 0);
    pulse_fs();
    check_lit("show_42", 0, 0, 4, 2, 0, 0);

    do_load(16383);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_lit("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_fs();
    check_lit("after_reset_fs", 0, 0, 0, 0, 0, 0);
    do_load(5);
    wait_idle();
    pulse_fs();
    check_lit("show_5", 0, 0, 0, 5, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
